// File: rtl/dcache_write_buffer_pkg.sv
// rtl/dcache_write_buffer_pkg.sv - shared defines for the DCache write-back buffer
//
// Purpose: drain FSM state encoding and the bus widths shared by the write
// buffer and its lookup CAM.
// Ports: none (package).

package dcache_write_buffer_pkg;

  localparam int WB_DEPTH        = 4;
  localparam int LINE_OFFSET_W   = 5;    // 32-byte lines
  localparam int WAY_BUS_W       = 256;  // one cache line, 8 x 32-bit words
  localparam int DATA_ADDR_BUS_W = 32;   // byte address into the data interface

  typedef enum logic {
    STATE_WB_IDLE = 1'b0,
    STATE_WB_BUSY = 1'b1
  } wb_state_e;

endpackage

// File: rtl/dcache_write_buffer_wb_lookup_cam.sv
// rtl/dcache_write_buffer_wb_lookup_cam.sv - tag CAM with newest-first select
//
// Purpose: compares a lookup tag and a push tag against every valid entry.
// The lookup hit takes the newest matching entry (closest to the tail); the
// push match skips the head while it is draining so it is never rewritten.
// Ports:
//   i_lookup_key / i_push_key : line tags to search for
//   i_tags / i_valid          : entry tags and valid bits
//   i_head / i_tail / i_busy  : ring pointers and drain state
//   o_hit / o_hit_idx         : lookup result
//   o_merge / o_merge_idx     : push-merge target

module wb_lookup_cam
  import dcache_write_buffer_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  parameter  int TAG_W = DATA_ADDR_BUS_W - LINE_OFFSET_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]            i_lookup_key,
  input  logic [TAG_W-1:0]            i_push_key,
  input  logic [DEPTH-1:0][TAG_W-1:0] i_tags,
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [PTR_W-1:0]            i_head,
  input  logic [PTR_W-1:0]            i_tail,
  input  logic                        i_busy,
  output logic                        o_hit,
  output logic [PTR_W-1:0]            o_hit_idx,
  output logic                        o_merge,
  output logic [PTR_W-1:0]            o_merge_idx
);

  logic [DEPTH-1:0] w_lookup_match;
  logic [DEPTH-1:0] w_push_match;
  logic [DEPTH-1:0] w_head_mask;

  // Walk from the tail (oldest slot) towards tail-1 (newest); the last
  // match seen wins, which gives newest-first priority.
  function automatic logic [PTR_W:0] newest(input logic [DEPTH-1:0] m,
                                            input logic [PTR_W-1:0] tail);
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   res;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail + PTR_W'(k);
      if (m[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_head_mask = i_busy ? (DEPTH'(1) << i_head) : '0;

  always_comb begin
    w_lookup_match = '0;
    w_push_match   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_lookup_match[i] = i_valid[i] && (i_tags[i] == i_lookup_key);
      w_push_match[i]   = i_valid[i] && (i_tags[i] == i_push_key);
    end
    w_push_match = w_push_match & ~w_head_mask;
  end

  assign {o_hit, o_hit_idx}     = newest(w_lookup_match, i_tail);
  assign {o_merge, o_merge_idx} = newest(w_push_match, i_tail);

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - FIFO write-back buffer for evicted dirty lines
//
// Purpose: queues whole dirty lines from the DCache, merges repeat evictions
// of a queued line, drains lines one at a time to the cache/AXI interface
// and lets a miss be served from a queued line.
// Ports:
//   clk, rst (async, active low)
//   wb_push_*        : line push from the DCache
//   wb_full/empty/count_o : occupancy, from the registered count
//   wb_lookup_addr_i / wb_hit_o / wb_hit_data_o : combinational lookup
//   data_wen_o / data_awaddr_o / data_wdata_o / data_bvalid_i : drain handshake

module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter  int DEPTH  = WB_DEPTH,
  parameter  int ADDR_W = DATA_ADDR_BUS_W,
  parameter  int LINE_W = WAY_BUS_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int TAG_W  = ADDR_W - LINE_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_push_i,
  input  logic [ADDR_W-1:0] wb_push_addr_i,
  input  logic [LINE_W-1:0] wb_push_data_i,
  output logic              wb_full_o,
  output logic              wb_empty_o,
  output logic [CNT_W-1:0]  wb_count_o,
  input  logic [ADDR_W-1:0] wb_lookup_addr_i,
  output logic              wb_hit_o,
  output logic [LINE_W-1:0] wb_hit_data_o,
  output logic              data_wen_o,
  output logic [ADDR_W-1:0] data_awaddr_o,
  output logic [LINE_W-1:0] data_wdata_o,
  input  logic              data_bvalid_i
);

  wb_state_e                 r_state, w_state_nxt;
  logic [PTR_W-1:0]          r_head, r_tail;
  logic [CNT_W-1:0]          r_count, w_count_nxt;
  logic [DEPTH-1:0]          r_valid;
  logic [DEPTH-1:0][TAG_W-1:0] r_tag;
  logic [LINE_W-1:0]         r_data [DEPTH];

  logic             w_busy, w_full, w_push, w_pop, w_merge, w_alloc;
  logic [TAG_W-1:0] w_push_tag, w_lookup_tag;
  logic             w_hit, w_merge_hit;
  logic [PTR_W-1:0] w_hit_idx, w_merge_idx;
  logic             w_unused_offset;

  assign w_busy       = (r_state == STATE_WB_BUSY);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_push       = wb_push_i && !w_full;
  assign w_pop        = w_busy && data_bvalid_i;
  assign w_push_tag   = wb_push_addr_i[ADDR_W-1:LINE_OFFSET_W];
  assign w_lookup_tag = wb_lookup_addr_i[ADDR_W-1:LINE_OFFSET_W];
  assign w_unused_offset = ^{wb_push_addr_i[LINE_OFFSET_W-1:0],
                             wb_lookup_addr_i[LINE_OFFSET_W-1:0]};

  wb_lookup_cam #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_cam (
    .i_lookup_key (w_lookup_tag),
    .i_push_key   (w_push_tag),
    .i_tags       (r_tag),
    .i_valid      (r_valid),
    .i_head       (r_head),
    .i_tail       (r_tail),
    .i_busy       (w_busy),
    .o_hit        (w_hit),
    .o_hit_idx    (w_hit_idx),
    .o_merge      (w_merge_hit),
    .o_merge_idx  (w_merge_idx)
  );

  assign w_merge     = w_push && w_merge_hit;
  assign w_alloc     = w_push && !w_merge_hit;
  assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    data_wen_o  = 1'b0;
    case (r_state)
      STATE_WB_IDLE: begin
        if (r_count != '0) w_state_nxt = STATE_WB_BUSY;
      end
      STATE_WB_BUSY: begin
        // wen drops in the bvalid cycle so the interface cannot relaunch
        data_wen_o = !data_bvalid_i;
        if (w_pop && (w_count_nxt == '0)) w_state_nxt = STATE_WB_IDLE;
      end
      default: w_state_nxt = STATE_WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STATE_WB_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tag[r_tail]   <= w_push_tag;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
    end
  end

  // Line data is qualified by r_valid / state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc)      r_data[r_tail]      <= wb_push_data_i;
    else if (w_merge) r_data[w_merge_idx] <= wb_push_data_i;
  end

  assign wb_full_o     = w_full;
  assign wb_empty_o    = (r_count == '0);
  assign wb_count_o    = r_count;
  assign wb_hit_o      = w_hit;
  assign wb_hit_data_o = w_hit ? r_data[w_hit_idx] : '0;
  assign data_awaddr_o = w_busy ? {r_tag[r_head], LINE_OFFSET_W'(0)} : '0;
  assign data_wdata_o  = w_busy ? r_data[r_head] : '0;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - randomized self-checking bench for the write buffer

module tb_dcache_write_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_push_i;
  logic [31:0]  wb_push_addr_i;
  logic [255:0] wb_push_data_i;
  logic         wb_full_o, wb_empty_o, wb_hit_o;
  logic [2:0]   wb_count_o;
  logic [31:0]  wb_lookup_addr_i;
  logic [255:0] wb_hit_data_o;
  logic         data_wen_o;
  logic [31:0]  data_awaddr_o;
  logic [255:0] data_wdata_o;
  logic         data_bvalid_i;

  always #5 clk = ~clk;

  dcache_write_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .wb_push_i        (wb_push_i),
    .wb_push_addr_i   (wb_push_addr_i),
    .wb_push_data_i   (wb_push_data_i),
    .wb_full_o        (wb_full_o),
    .wb_empty_o       (wb_empty_o),
    .wb_count_o       (wb_count_o),
    .wb_lookup_addr_i (wb_lookup_addr_i),
    .wb_hit_o         (wb_hit_o),
    .wb_hit_data_o    (wb_hit_data_o),
    .data_wen_o       (data_wen_o),
    .data_awaddr_o    (data_awaddr_o),
    .data_wdata_o     (data_wdata_o),
    .data_bvalid_i    (data_bvalid_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of queued lines, oldest at index 0, plus drain flag.
  logic [26:0]  qt[$];
  logic [255:0] qd[$];
  bit           m_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic compare_all();
    logic [255:0] ehd, ewd;
    logic [31:0]  eaddr;
    bit           ehit;
    int           n;
    n = qt.size();
    ehit = 1'b0; ehd = '0; ewd = '0; eaddr = '0;
    for (int i = 0; i < n; i++)
      if (qt[i] == wb_lookup_addr_i[31:5]) begin ehit = 1'b1; ehd = qd[i]; end
    if (m_busy) begin eaddr = {qt[0], 5'd0}; ewd = qd[0]; end
    check_eq("wen",      data_wen_o,    m_busy && !data_bvalid_i);
    check_eq("awaddr",   data_awaddr_o, eaddr);
    check_eq("wdata",    data_wdata_o,  ewd);
    check_eq("full",     wb_full_o,     n == 4);
    check_eq("empty",    wb_empty_o,    n == 0);
    check_eq("count",    wb_count_o,    n);
    check_eq("hit",      wb_hit_o,      ehit);
    check_eq("hit_data", wb_hit_data_o, ehd);
  endtask

  task automatic model_update(input bit push, input logic [31:0] paddr,
                              input logic [255:0] pdata, input bit bv);
    int  n0;
    int  j;
    bit  pop;
    n0  = qt.size();
    pop = m_busy && bv;
    if (push && n0 < 4) begin
      j = -1;
      for (int i = 0; i < n0; i++)
        if (qt[i] == paddr[31:5] && (i != 0 || !m_busy)) j = i;
      if (j >= 0) qd[j] = pdata;
      else begin qt.push_back(paddr[31:5]); qd.push_back(pdata); end
    end
    if (pop) begin void'(qt.pop_front()); void'(qd.pop_front()); end
    if (!m_busy) m_busy = (n0 != 0);
    else if (pop) m_busy = (qt.size() != 0);
  endtask

  // Entered and left at posedge+1: drive, settle, compare, clock, update model.
  task automatic cycle(input bit push, input logic [31:0] paddr, input logic [255:0] pdata,
                       input logic [31:0] laddr, input bit bv);
    wb_push_i        = push;
    wb_push_addr_i   = paddr;
    wb_push_data_i   = pdata;
    wb_lookup_addr_i = laddr;
    data_bvalid_i    = bv;
    #1;
    compare_all();
    @(posedge clk);
    model_update(push, paddr, pdata, bv);
    #1;
  endtask

  task automatic idle(input int n, input bit bv);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, '0, 32'h0, bv);
  endtask

  logic [255:0] d_a, d_x, d_y, d_z;
  logic [31:0]  pool [6];

  initial begin
    rst = 1'b0;
    wb_push_i = 1'b0; wb_push_addr_i = '0; wb_push_data_i = '0;
    wb_lookup_addr_i = '0; data_bvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wen",   data_wen_o,    1'b0);
    check_eq("rst_empty", wb_empty_o,    1'b1);
    check_eq("rst_count", wb_count_o,    3'd0);
    check_eq("rst_awadr", data_awaddr_o, 32'h0);
    rst = 1'b1;

    // single line
    for (int k = 0; k < 8; k++) d_a[k*32 +: 32] = 32'hA0 + k;
    cycle(1'b1, 32'h0000_1024, d_a, 32'h0000_1000, 1'b0);
    idle(1, 1'b0);
    #0 check_eq("single_wen",  data_wen_o,    1'b1);
    check_eq("single_addr", data_awaddr_o, 32'h0000_1020);
    check_eq("single_data", data_wdata_o,  d_a);
    cycle(1'b0, 32'h0, '0, 32'h0000_1020, 1'b1);
    idle(1, 1'b0);
    check_eq("single_empty", wb_empty_o, 1'b1);

    // fill, ignored 5th push, drain in order
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_2000 + 32'(i) * 32'h20, rand_line(), 32'h0000_2040, 1'b0);
    check_eq("fill_full",  wb_full_o,  1'b1);
    check_eq("fill_count", wb_count_o, 3'd4);
    for (int i = 0; i < 4; i++) begin idle(1, 1'b0); idle(1, 1'b1); end
    idle(2, 1'b0);

    // merge into a non-head entry while the head drains
    d_x = rand_line(); d_y = rand_line();
    cycle(1'b1, 32'h100, d_x, 32'h200, 1'b0);
    cycle(1'b1, 32'h200, rand_line(), 32'h200, 1'b0);
    cycle(1'b1, 32'h200, d_y, 32'h200, 1'b0);
    check_eq("merge_count", wb_count_o, 3'd2);
    idle(1, 1'b1);
    check_eq("merge_data", data_wdata_o, d_y);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // head protection
    d_z = rand_line();
    cycle(1'b1, 32'h100, d_x, 32'h100, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 32'h100, d_z, 32'h100, 1'b0);
    check_eq("hp_count", wb_count_o, 3'd2);
    wb_lookup_addr_i = 32'h100; #1;
    check_eq("hp_hit_data", wb_hit_data_o, d_z);
    check_eq("hp_head",     data_wdata_o,  d_x);
    cycle(1'b0, 32'h0, '0, 32'h100, 1'b1);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // simultaneous push + pop
    cycle(1'b1, 32'h300, rand_line(), 32'h0, 1'b0);
    cycle(1'b1, 32'h320, rand_line(), 32'h0, 1'b0);
    cycle(1'b1, 32'h340, rand_line(), 32'h0, 1'b1);
    check_eq("sim_count", wb_count_o, 3'd2);
    check_eq("sim_addr",  data_awaddr_o, 32'h320);
    idle(4, 1'b1);
    idle(2, 1'b0);

    // reset mid-drain
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(i) * 32'h20, rand_line(), 32'h0, 1'b0);
    idle(1, 1'b0);
    wb_lookup_addr_i = 32'h500;
    #1 rst = 1'b0;
    #1;
    check_eq("rmd_wen",   data_wen_o,    1'b0);
    check_eq("rmd_full",  wb_full_o,     1'b0);
    check_eq("rmd_empty", wb_empty_o,    1'b1);
    check_eq("rmd_count", wb_count_o,    3'd0);
    check_eq("rmd_hit",   wb_hit_o,      1'b0);
    check_eq("rmd_addr",  data_awaddr_o, 32'h0);
    check_eq("rmd_data",  data_wdata_o,  256'h0);
    qt.delete(); qd.delete(); m_busy = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    idle(4, 1'b0);

    // randomized traffic on a small line pool to provoke merges and hits
    for (int i = 0; i < 6; i++) pool[i] = 32'h0000_4000 + 32'(i) * 32'h20;
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 1) == 1,
            pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 31)),
            rand_line(),
            pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
